// File: rtl/riscv_opcodes_pkg.sv
// Opcode/funct constants, INSTR_NOP, the encoder mnemonic enum and the
// per-mnemonic format table used by riscv_instr_encoder.
package riscv_opcodes_pkg;

    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
    localparam logic [6:0] OPC_OP32     = 7'b0111011;

    localparam logic [2:0] F3_ADD  = 3'd0;
    localparam logic [2:0] F3_SLL  = 3'd1;
    localparam logic [2:0] F3_SLT  = 3'd2;
    localparam logic [2:0] F3_SLTU = 3'd3;
    localparam logic [2:0] F3_XOR  = 3'd4;
    localparam logic [2:0] F3_SR   = 3'd5;
    localparam logic [2:0] F3_OR   = 3'd6;
    localparam logic [2:0] F3_AND  = 3'd7;

    localparam logic [2:0] F3_BEQ  = 3'd0;
    localparam logic [2:0] F3_BNE  = 3'd1;
    localparam logic [2:0] F3_BLT  = 3'd4;
    localparam logic [2:0] F3_BGE  = 3'd5;
    localparam logic [2:0] F3_BLTU = 3'd6;
    localparam logic [2:0] F3_BGEU = 3'd7;

    localparam logic [2:0] F3_B    = 3'd0;
    localparam logic [2:0] F3_H    = 3'd1;
    localparam logic [2:0] F3_W    = 3'd2;
    localparam logic [2:0] F3_D    = 3'd3;
    localparam logic [2:0] F3_BU   = 3'd4;
    localparam logic [2:0] F3_HU   = 3'd5;
    localparam logic [2:0] F3_WU   = 3'd6;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;  // bit 30: SUB / arithmetic shift

    localparam logic [31:0] INSTR_FENCE  = 32'h0FF0_000F;
    localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;
    localparam logic [31:0] INSTR_MRET   = 32'h3020_0073;
    localparam logic [31:0] INSTR_SRET   = 32'h1020_0073;
    localparam logic [31:0] INSTR_WFI    = 32'h1050_0073;

    typedef enum logic [5:0] {
        OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
        OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
        OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
        OP_SB, OP_SH, OP_SW,
        OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI,
        OP_SLLI, OP_SRLI, OP_SRAI,
        OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
        OP_FENCE, OP_ECALL, OP_EBREAK, OP_MRET, OP_SRET, OP_WFI,
        OP_LD, OP_SD, OP_LWU, OP_ADDIW, OP_ADDW, OP_SUBW, OP_SLLW, OP_SRLW, OP_SRAW,
        OP_SLLIW, OP_SRLIW, OP_SRAIW
    } enc_op_t;

    // FMT_SH is the I-format with a shift amount instead of a signed immediate
    typedef enum logic [3:0] {
        FMT_R, FMT_I, FMT_SH, FMT_S, FMT_B, FMT_U, FMT_J, FMT_FIX, FMT_BAD
    } enc_fmt_t;

    typedef struct packed {
        enc_fmt_t    fmt;
        logic        rv64;     // only legal with the RV64 extension built in
        logic        w_shift;  // 32-bit word shift: shamt limited to 5 bits
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] fixed;    // full word for FMT_FIX
    } op_info_t;

    function automatic op_info_t ent(enc_fmt_t fmt, logic [6:0] opc, logic [2:0] f3,
                                     logic [6:0] f7, logic rv64, logic wsh, logic [31:0] fixed);
        op_info_t e;
        e.fmt = fmt; e.opcode = opc; e.funct3 = f3; e.funct7 = f7;
        e.rv64 = rv64; e.w_shift = wsh; e.fixed = fixed;
        return e;
    endfunction

    // Per-mnemonic format table
    function automatic op_info_t op_info(enc_op_t op);
        case (op)
            OP_LUI:    return ent(FMT_U, OPC_LUI,      3'd0,    F7_BASE, 1'b0, 1'b0, 32'd0);
            OP_AUIPC:  return ent(FMT_U, OPC_AUIPC,    3'd0,    F7_BASE, 1'b0, 1'b0, 32'd0);
            OP_JAL:    return ent(FMT_J, OPC_JAL,      3'd0,    F7_BASE, 1'b0, 1'b0, 32'd0);
            OP_JALR:   return ent(FMT_I, OPC_JALR,     3'd0,    F7_BASE, 1'b0, 1'b0, 32'd0);
            OP_BEQ:    return ent(FMT_B, OPC_BRANCH,   F3_BEQ,  F7_BASE, 1'b0, 1'b0, 32'd0);
            OP_BNE:    return ent(FMT_B, OPC_BRANCH,   F3_BNE,  F7_BASE, 1'b0, 1'b0, 32'd0);
            OP_BLT:    return ent(FMT_B, OPC_BRANCH,   F3_BLT,  F7_BASE, 1'b0, 1'b0, 32'd0);
            OP_BGE:    return ent(FMT_B, OPC_BRANCH,   F3_BGE,  F7_BASE, 1'b0, 1'b0, 32'd0);
            OP_BLTU:   return ent(FMT_B, OPC_BRANCH,   F3_BLTU, F7_BASE, 1'b0, 1'b0, 32'd0);
            OP_BGEU:   return ent(FMT_B, OPC_BRANCH,   F3_BGEU, F7_BASE, 1'b0, 1'b0, 32'd0);
            OP_LB:     return ent(FMT_I, OPC_LOAD,     F3_B,    F7_BASE, 1'b0, 1'b0, 32'd0);
            OP_LH:     return ent(FMT_I, OPC_LOAD,     F3_H,    F7_BASE, 1'b0, 1'b0, 32'd0);
            OP_LW:     return ent(FMT_I, OPC_LOAD,     F3_W,    F7_BASE, 1'b0, 1'b0, 32'd0);
            OP_LBU:    return ent(FMT_I, OPC_LOAD,     F3_BU,   F7_BASE, 1'b0, 1'b0, 32'd0);
            OP_LHU:    return ent(FMT_I, OPC_LOAD,     F3_HU,   F7_BASE, 1'b0, 1'b0, 32'd0);
            OP_SB:     return ent(FMT_S, OPC_STORE,    F3_B,    F7_BASE, 1'b0, 1'b0, 32'd0);
            OP_SH:     return ent(FMT_S, OPC_STORE,    F3_H,    F7_BASE, 1'b0, 1'b0, 32'd0);
            OP_SW:     return ent(FMT_S, OPC_STORE,    F3_W,    F7_BASE, 1'b0, 1'b0, 32'd0);
            OP_ADDI:   return ent(FMT_I, OPC_OP_IMM,   F3_ADD,  F7_BASE, 1'b0, 1'b0, 32'd0);
            OP_SLTI:   return ent(FMT_I, OPC_OP_IMM,   F3_SLT,  F7_BASE, 1'b0, 1'b0, 32'd0);
            OP_SLTIU:  return ent(FMT_I, OPC_OP_IMM,   F3_SLTU, F7_BASE, 1'b0, 1'b0, 32'd0);
            OP_XORI:   return ent(FMT_I, OPC_OP_IMM,   F3_XOR,  F7_BASE, 1'b0, 1'b0, 32'd0);
            OP_ORI:    return ent(FMT_I, OPC_OP_IMM,   F3_OR,   F7_BASE, 1'b0, 1'b0, 32'd0);
            OP_ANDI:   return ent(FMT_I, OPC_OP_IMM,   F3_AND,  F7_BASE, 1'b0, 1'b0, 32'd0);
            OP_SLLI:   return ent(FMT_SH, OPC_OP_IMM,  F3_SLL,  F7_BASE, 1'b0, 1'b0, 32'd0);
            OP_SRLI:   return ent(FMT_SH, OPC_OP_IMM,  F3_SR,   F7_BASE, 1'b0, 1'b0, 32'd0);
            OP_SRAI:   return ent(FMT_SH, OPC_OP_IMM,  F3_SR,   F7_ALT,  1'b0, 1'b0, 32'd0);
            OP_ADD:    return ent(FMT_R, OPC_OP,       F3_ADD,  F7_BASE, 1'b0, 1'b0, 32'd0);
            OP_SUB:    return ent(FMT_R, OPC_OP,       F3_ADD,  F7_ALT,  1'b0, 1'b0, 32'd0);
            OP_SLL:    return ent(FMT_R, OPC_OP,       F3_SLL,  F7_BASE, 1'b0, 1'b0, 32'd0);
            OP_SLT:    return ent(FMT_R, OPC_OP,       F3_SLT,  F7_BASE, 1'b0, 1'b0, 32'd0);
            OP_SLTU:   return ent(FMT_R, OPC_OP,       F3_SLTU, F7_BASE, 1'b0, 1'b0, 32'd0);
            OP_XOR:    return ent(FMT_R, OPC_OP,       F3_XOR,  F7_BASE, 1'b0, 1'b0, 32'd0);
            OP_SRL:    return ent(FMT_R, OPC_OP,       F3_SR,   F7_BASE, 1'b0, 1'b0, 32'd0);
            OP_SRA:    return ent(FMT_R, OPC_OP,       F3_SR,   F7_ALT,  1'b0, 1'b0, 32'd0);
            OP_OR:     return ent(FMT_R, OPC_OP,       F3_OR,   F7_BASE, 1'b0, 1'b0, 32'd0);
            OP_AND:    return ent(FMT_R, OPC_OP,       F3_AND,  F7_BASE, 1'b0, 1'b0, 32'd0);
            OP_FENCE:  return ent(FMT_FIX, 7'd0, 3'd0, F7_BASE, 1'b0, 1'b0, INSTR_FENCE);
            OP_ECALL:  return ent(FMT_FIX, 7'd0, 3'd0, F7_BASE, 1'b0, 1'b0, INSTR_ECALL);
            OP_EBREAK: return ent(FMT_FIX, 7'd0, 3'd0, F7_BASE, 1'b0, 1'b0, INSTR_EBREAK);
            OP_MRET:   return ent(FMT_FIX, 7'd0, 3'd0, F7_BASE, 1'b0, 1'b0, INSTR_MRET);
            OP_SRET:   return ent(FMT_FIX, 7'd0, 3'd0, F7_BASE, 1'b0, 1'b0, INSTR_SRET);
            OP_WFI:    return ent(FMT_FIX, 7'd0, 3'd0, F7_BASE, 1'b0, 1'b0, INSTR_WFI);
            OP_LD:     return ent(FMT_I, OPC_LOAD,     F3_D,    F7_BASE, 1'b1, 1'b0, 32'd0);
            OP_SD:     return ent(FMT_S, OPC_STORE,    F3_D,    F7_BASE, 1'b1, 1'b0, 32'd0);
            OP_LWU:    return ent(FMT_I, OPC_LOAD,     F3_WU,   F7_BASE, 1'b1, 1'b0, 32'd0);
            OP_ADDIW:  return ent(FMT_I, OPC_OP_IMM32, F3_ADD,  F7_BASE, 1'b1, 1'b0, 32'd0);
            OP_ADDW:   return ent(FMT_R, OPC_OP32,     F3_ADD,  F7_BASE, 1'b1, 1'b0, 32'd0);
            OP_SUBW:   return ent(FMT_R, OPC_OP32,     F3_ADD,  F7_ALT,  1'b1, 1'b0, 32'd0);
            OP_SLLW:   return ent(FMT_R, OPC_OP32,     F3_SLL,  F7_BASE, 1'b1, 1'b0, 32'd0);
            OP_SRLW:   return ent(FMT_R, OPC_OP32,     F3_SR,   F7_BASE, 1'b1, 1'b0, 32'd0);
            OP_SRAW:   return ent(FMT_R, OPC_OP32,     F3_SR,   F7_ALT,  1'b1, 1'b0, 32'd0);
            OP_SLLIW:  return ent(FMT_SH, OPC_OP_IMM32, F3_SLL, F7_BASE, 1'b1, 1'b1, 32'd0);
            OP_SRLIW:  return ent(FMT_SH, OPC_OP_IMM32, F3_SR,  F7_BASE, 1'b1, 1'b1, 32'd0);
            OP_SRAIW:  return ent(FMT_SH, OPC_OP_IMM32, F3_SR,  F7_ALT,  1'b1, 1'b1, 32'd0);
            default:   return ent(FMT_BAD, 7'd0, 3'd0, F7_BASE, 1'b0, 1'b0, 32'd0);
        endcase
    endfunction

endpackage

// File: rtl/riscv_enc_queue.sv
// Synchronous FIFO of {err, instr} words with full/empty flags.
// Head entry is presented combinationally from storage; pointers wrap mod DEPTH.
module riscv_enc_queue #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 33
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count;
    logic             do_push, do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Pointer and occupancy tracking; push+pop together leaves count unchanged
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage write; contents need no reset since empty masks them
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/riscv_instr_encoder.sv
// RISC-V instruction encoder: mnemonic + operands -> 32-bit word, queued.
// Illegal ops and out-of-range immediates enqueue INSTR_NOP with err set.
// Optional feature macro: RV64_ENCODE_EN (RV64 ops, 6-bit shamt, XLEN=64).
module riscv_instr_encoder
    import riscv_opcodes_pkg::*;
#(
    parameter int QUEUE_DEPTH = 4,
    parameter int XLEN        = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  enc_op_t         req_op,
    input  logic [4:0]      req_rd,
    input  logic [4:0]      req_rs1,
    input  logic [4:0]      req_rs2,
    input  logic [XLEN-1:0] req_imm,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_instr,
    output logic            out_err
);

`ifdef RV64_ENCODE_EN
    localparam bit RV64_OK = 1'b1;
    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("riscv_instr_encoder: XLEN must be 32 or 64");
    end
`else
    localparam bit RV64_OK = 1'b0;
    if (XLEN != 32) begin : g_bad_xlen
        $error("riscv_instr_encoder: XLEN must be 32 without RV64_ENCODE_EN");
    end
`endif

    if (QUEUE_DEPTH < 2 || (QUEUE_DEPTH & (QUEUE_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("riscv_instr_encoder: QUEUE_DEPTH must be a power of 2, >= 2");
    end

    // True when v is representable as a signed bits-wide value
    function automatic logic fits_s(input logic [XLEN-1:0] v, input int bits);
        logic ok = 1'b1;
        for (int i = 0; i < XLEN; i++)
            if (i >= bits && v[i] != v[bits-1]) ok = 1'b0;
        return ok;
    endfunction

    // True when v < 2**bits as an unsigned value
    function automatic logic fits_u(input logic [XLEN-1:0] v, input int bits);
        logic ok = 1'b1;
        for (int i = 0; i < XLEN; i++)
            if (i >= bits && v[i]) ok = 1'b0;
        return ok;
    endfunction

    op_info_t    info;
    logic [31:0] enc_word;
    logic        enc_err;
    logic        fmt_bad, imm_ok;
    logic        q_full, q_empty, push, pop;
    logic [32:0] q_rdata;

    // Format-driven encoding with range checks; failures collapse to NOP+err
    always_comb begin
        info     = op_info(req_op);
        enc_word = INSTR_NOP;
        enc_err  = 1'b0;
        fmt_bad  = 1'b0;
        imm_ok   = 1'b1;
        case (info.fmt)
            FMT_R: enc_word = {info.funct7, req_rs2, req_rs1, info.funct3, req_rd, info.opcode};
            FMT_I: begin
                imm_ok   = fits_s(req_imm, 12);
                enc_word = {req_imm[11:0], req_rs1, info.funct3, req_rd, info.opcode};
            end
            FMT_SH: begin
                // shamt[5] lands on funct7[0], which is zero for every shift
                imm_ok   = fits_u(req_imm, (RV64_OK && !info.w_shift) ? 6 : 5);
                enc_word = {info.funct7[6:1], req_imm[5:0], req_rs1, info.funct3, req_rd, info.opcode};
            end
            FMT_S: begin
                imm_ok   = fits_s(req_imm, 12);
                enc_word = {req_imm[11:5], req_rs2, req_rs1, info.funct3, req_imm[4:0], info.opcode};
            end
            FMT_B: begin
                imm_ok   = fits_s(req_imm, 13) && !req_imm[0];
                enc_word = {req_imm[12], req_imm[10:5], req_rs2, req_rs1, info.funct3,
                            req_imm[4:1], req_imm[11], info.opcode};
            end
            FMT_U: begin
                imm_ok   = (req_imm[11:0] == 12'd0) && fits_s(req_imm, 32);
                enc_word = {req_imm[31:12], req_rd, info.opcode};
            end
            FMT_J: begin
                imm_ok   = fits_s(req_imm, 21) && !req_imm[0];
                enc_word = {req_imm[20], req_imm[10:1], req_imm[11], req_imm[19:12],
                            req_rd, info.opcode};
            end
            FMT_FIX: enc_word = info.fixed;
            default: fmt_bad  = 1'b1;
        endcase
        if (info.rv64 && !RV64_OK) fmt_bad = 1'b1;
        if (fmt_bad || !imm_ok) begin
            enc_word = INSTR_NOP;
            enc_err  = 1'b1;
        end
    end

    assign req_ready = !q_full;
    assign push      = req_valid && req_ready;
    assign pop       = out_valid && out_ready;

    riscv_enc_queue #(
        .DEPTH (QUEUE_DEPTH),
        .WIDTH (33)
    ) u_queue (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata ({enc_err, enc_word}),
        .pop   (pop),
        .rdata (q_rdata),
        .full  (q_full),
        .empty (q_empty)
    );

    assign out_valid = !q_empty;
    assign out_instr = q_empty ? INSTR_NOP : q_rdata[31:0];
    assign out_err   = !q_empty && q_rdata[32];

endmodule

// File: tb/tb_riscv_instr_encoder.sv
// Directed self-checking bench for riscv_instr_encoder (hand-computed words).
module tb_riscv_instr_encoder;
    import riscv_opcodes_pkg::*;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            req_valid = 1'b0;
    logic            req_ready;
    enc_op_t         req_op = OP_ADDI;
    logic [4:0]      req_rd = '0, req_rs1 = '0, req_rs2 = '0;
    logic [XLEN-1:0] req_imm = '0;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [31:0]     out_instr;
    logic            out_err;

    int n_tests = 0;
    int n_fail  = 0;

    riscv_instr_encoder #(.QUEUE_DEPTH(4), .XLEN(XLEN)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_rd    (req_rd),
        .req_rs1   (req_rs1),
        .req_rs2   (req_rs2),
        .req_imm   (req_imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input enc_op_t op, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [XLEN-1:0] imm);
        req_op = op; req_rd = rd; req_rs1 = rs1; req_rs2 = rs2; req_imm = imm;
        req_valid = 1'b1;
    endtask

    // One request into an empty queue with out_ready high: word visible one
    // cycle after acceptance, then popped on the following edge.
    task automatic send_chk(input string tag, input enc_op_t op, input logic [4:0] rd,
                            input logic [4:0] rs1, input logic [4:0] rs2,
                            input logic [XLEN-1:0] imm, input logic [31:0] exp_w,
                            input logic exp_e);
        drive(op, rd, rs1, rs2, imm);
        step();
        req_valid = 1'b0;
        chk({tag, ".valid"}, 64'(out_valid), 64'(1'b1));
        chk({tag, ".instr"}, 64'(out_instr), 64'(exp_w));
        chk({tag, ".err"},   64'(out_err),   64'(exp_e));
        step();
    endtask

    initial begin
        // reset state
        #2;
        chk("rst.valid", 64'(out_valid), 64'(1'b0));
        chk("rst.instr", 64'(out_instr), 64'h13);
        chk("rst.err",   64'(out_err),   64'(1'b0));
        #10 rst = 1'b0;
        step();
        chk("rst.ready", 64'(req_ready), 64'(1'b1));

        // basic encodings
        send_chk("addi",     OP_ADDI, 5'd1, 5'd0, 5'd0, 32'd5,        32'h0050_0093, 1'b0);
        chk("addi.popped", 64'(out_valid), 64'(1'b0));
        send_chk("addi_max", OP_ADDI, 5'd1, 5'd0, 5'd0, 32'd2047,     32'h7FF0_0093, 1'b0);
        send_chk("addi_min", OP_ADDI, 5'd1, 5'd0, 5'd0, 32'hFFFF_F800, 32'h8000_0093, 1'b0);
        send_chk("sub",      OP_SUB,  5'd3, 5'd1, 5'd2, 32'd0,        32'h4020_81B3, 1'b0);
        send_chk("srai",     OP_SRAI, 5'd1, 5'd2, 5'd0, 32'd3,        32'h4031_5093, 1'b0);
        send_chk("sw",       OP_SW,   5'd0, 5'd2, 5'd1, 32'd8,        32'h0011_2423, 1'b0);
        send_chk("jal",      OP_JAL,  5'd1, 5'd0, 5'd0, 32'd8,        32'h0080_00EF, 1'b0);
        send_chk("beq_neg",  OP_BEQ,  5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC, 32'hFE20_8EE3, 1'b0);
        send_chk("ecall",    OP_ECALL, 5'd7, 5'd9, 5'd3, 32'h55,      32'h0000_0073, 1'b0);

        // range / legality errors
        send_chk("beq_odd",  OP_BEQ,  5'd0, 5'd1, 5'd2, 32'd3,        32'h13, 1'b1);
        send_chk("addi_big", OP_ADDI, 5'd1, 5'd0, 5'd0, 32'd2048,     32'h13, 1'b1);
        send_chk("lui_low",  OP_LUI,  5'd2, 5'd0, 5'd0, 32'h1234_5001, 32'h13, 1'b1);
        send_chk("slli_32",  OP_SLLI, 5'd1, 5'd1, 5'd0, 32'd32,       32'h13, 1'b1);
        send_chk("slliw_32", OP_SLLIW, 5'd1, 5'd1, 5'd0, 32'd32,      32'h13, 1'b1);
`ifdef RV64_ENCODE_EN
        send_chk("addw",     OP_ADDW, 5'd1, 5'd2, 5'd3, 32'd0,        32'h0031_00BB, 1'b0);
`else
        send_chk("addw",     OP_ADDW, 5'd1, 5'd2, 5'd3, 32'd0,        32'h13, 1'b1);
`endif

        // back-to-back ADD then LUI
        drive(OP_ADD, 5'd3, 5'd1, 5'd2, 32'd0);
        step();
        drive(OP_LUI, 5'd2, 5'd0, 5'd0, 32'h1234_5000);
        chk("b2b.add", 64'(out_instr), 64'h0020_81B3);
        step();
        req_valid = 1'b0;
        chk("b2b.lui", 64'(out_instr), 64'h1234_5137);
        chk("b2b.lui_valid", 64'(out_valid), 64'(1'b1));
        step();
        chk("b2b.drained", 64'(out_valid), 64'(1'b0));

        // backpressure: fill 4, 5th blocked, then drain in order
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(OP_ADDI, 5'd1, 5'd0, 5'd0, XLEN'(i + 1));
            chk($sformatf("bp.ready%0d", i), 64'(req_ready), 64'(1'b1));
            step();
        end
        drive(OP_ADDI, 5'd1, 5'd0, 5'd0, 32'd5);
        chk("bp.full", 64'(req_ready), 64'(1'b0));
        step();
        chk("bp.full_hold", 64'(req_ready), 64'(1'b0));
        chk("bp.hold_instr", 64'(out_instr), 64'h0010_0093);
        out_ready = 1'b1;
        chk("bp.d1", 64'(out_instr), 64'h0010_0093);
        step();
        chk("bp.d2", 64'(out_instr), 64'h0020_0093);
        chk("bp.ready_again", 64'(req_ready), 64'(1'b1));
        step();
        req_valid = 1'b0;
        chk("bp.d3", 64'(out_instr), 64'h0030_0093);
        step();
        chk("bp.d4", 64'(out_instr), 64'h0040_0093);
        step();
        chk("bp.d5", 64'(out_instr), 64'h0050_0093);
        step();
        chk("bp.empty", 64'(out_valid), 64'(1'b0));

        // reset with 3 words queued
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(OP_ADDI, 5'd1, 5'd0, 5'd0, XLEN'(i + 7));
            step();
        end
        req_valid = 1'b0;
        chk("mr.queued", 64'(out_valid), 64'(1'b1));
        #2 rst = 1'b1;
        #1;
        chk("mr.valid", 64'(out_valid), 64'(1'b0));
        chk("mr.instr", 64'(out_instr), 64'h13);
        step();
        #2 rst = 1'b0;
        out_ready = 1'b1;
        step();
        chk("mr.no_stale", 64'(out_valid), 64'(1'b0));
        step();
        chk("mr.no_stale2", 64'(out_valid), 64'(1'b0));
        chk("mr.ready", 64'(req_ready), 64'(1'b1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
